// File: rtl/pmem_ctrl.sv
// Instruction fetch controller: assembles 16-bit instructions from a byte-wide
// program memory (two reads, little-endian) and serves repeats from a one-entry buffer.
module pmem_ctrl #(
    parameter int PC_WIDTH   = 12,
    parameter int PMEM_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_req,
    input  logic [PC_WIDTH-1:0]   in_pmem_addr,
    input  logic                  in_flush,
    input  logic                  in_inval,
    output logic [PMEM_WIDTH-1:0] out_instr,
    output logic                  out_instr_valid,
    output logic                  out_stall,
    output logic                  out_mem_rd,
    output logic [PC_WIDTH-1:0]   out_mem_addr,
    input  logic [7:0]            in_mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t                  state;
    logic                    buf_valid;
    logic [PC_WIDTH-1:0]     buf_addr;
    logic [PMEM_WIDTH-1:0]   buf_instr;
    logic [7:0]              lo_reg;
    logic [PC_WIDTH-1:0]     addr_reg;
    logic [PC_WIDTH-1:0]     addr_hold;
    logic [PC_WIDTH-1:0]     aligned_addr;
    logic [PC_WIDTH-1:0]     rd_addr;
    logic                    hit;
    logic                    unused_addr_lsb;

    assign aligned_addr    = {in_pmem_addr[PC_WIDTH-1:1], 1'b0};
    assign unused_addr_lsb = in_pmem_addr[0];
    assign hit = (state == IDLE) && in_req && buf_valid && (buf_addr == aligned_addr);

    // Read strobe and stall are combinational; the address falls back to the
    // last issued one so the memory bus stays quiet between fetches.
    always_comb begin
        out_mem_rd = 1'b0;
        out_stall  = 1'b0;
        rd_addr    = addr_hold;
        if (reset && !in_flush) begin
            case (state)
                IDLE: begin
                    if (in_req && !hit) begin
                        out_mem_rd = 1'b1;
                        out_stall  = 1'b1;
                        rd_addr    = aligned_addr;
                    end
                end
                LO: begin
                    out_mem_rd = 1'b1;
                    out_stall  = 1'b1;
                    // addr_reg is always even, so setting bit 0 is the +1 without a carry
                    rd_addr    = {addr_reg[PC_WIDTH-1:1], 1'b1};
                end
                HI: begin
                    out_stall = 1'b1;
                end
                default: ;
            endcase
        end
        out_mem_addr = rd_addr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            out_instr       <= '0;
            out_instr_valid <= 1'b0;
            buf_valid       <= 1'b0;
            buf_addr        <= '0;
            buf_instr       <= '0;
            lo_reg          <= '0;
            addr_reg        <= '0;
            addr_hold       <= '0;
        end else begin
            out_instr_valid <= 1'b0;
            if (out_mem_rd)
                addr_hold <= rd_addr;
            if (in_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            out_instr       <= buf_instr;
                            out_instr_valid <= 1'b1;
                        end else if (in_req) begin
                            addr_reg <= aligned_addr;
                            state    <= LO;
                        end
                    end
                    LO: begin
                        lo_reg <= in_mem_data;
                        state  <= HI;
                    end
                    HI: begin
                        out_instr       <= {in_mem_data, lo_reg};
                        out_instr_valid <= 1'b1;
                        buf_valid       <= 1'b1;
                        buf_addr        <= addr_reg;
                        buf_instr       <= {in_mem_data, lo_reg};
                        state           <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            // Invalidate wins over a buffer fill landing in the same cycle
            if (in_inval)
                buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pmem_ctrl.sv
// Randomized self-checking bench for pmem_ctrl against a transaction-level
// model of the fetch buffer and a byte-wide program memory.
module tb_pmem_ctrl;

    logic        clock;
    logic        reset;
    logic        in_req;
    logic [11:0] in_pmem_addr;
    logic        in_flush;
    logic        in_inval;
    logic [15:0] out_instr;
    logic        out_instr_valid;
    logic        out_stall;
    logic        out_mem_rd;
    logic [11:0] out_mem_addr;
    logic [7:0]  in_mem_data;

    pmem_ctrl #(.PC_WIDTH(12), .PMEM_WIDTH(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_req          (in_req),
        .in_pmem_addr    (in_pmem_addr),
        .in_flush        (in_flush),
        .in_inval        (in_inval),
        .out_instr       (out_instr),
        .out_instr_valid (out_instr_valid),
        .out_stall       (out_stall),
        .out_mem_rd      (out_mem_rd),
        .out_mem_addr    (out_mem_addr),
        .in_mem_data     (in_mem_data)
    );

    logic [7:0] mem [0:4095];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte memory: data appears the cycle after the strobe, garbage otherwise
    always @(posedge clock)
        in_mem_data <= out_mem_rd ? mem[out_mem_addr] : 8'($urandom);

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          mvalid;
    logic [11:0] maddr;
    logic [15:0] minstr;
    logic [11:0] mlast;
    bit          mlast_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic fetch(input logic [11:0] a, input int flush_at, input int inval_at);
        logic [11:0] aa;
        logic [15:0] exp;
        bit          hit;
        bit          flushed;
        bit          done;
        int          last;
        int          fa;
        aa   = {a[11:1], 1'b0};
        hit  = mvalid && (maddr == aa);
        exp  = hit ? minstr : {mem[aa | 12'd1], mem[aa]};
        last = hit ? 0 : 2;
        fa   = (flush_at > last) ? -1 : flush_at;
        flushed = 0;
        done    = 0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clock);
            in_pmem_addr = a;
            in_req       = (c <= last) && !flushed;
            in_flush     = (c == fa);
            in_inval     = (c == inval_at);
            #1;
            if (flushed || c > last) begin
                check("valid_out", out_instr_valid, !flushed);
                if (!flushed) check("instr", out_instr, exp);
                check("stall_end", out_stall, 0);
                check("rd_end", out_mem_rd, 0);
                done = 1;
            end else if (c == fa) begin
                check("stall_flush", out_stall, 0);
                check("valid_flush", out_instr_valid, 0);
                if (c == 0) check("rd_flush", out_mem_rd, 0);
                else mlast_known = 0;
                flushed = 1;
            end else begin
                check("valid_wait", out_instr_valid, 0);
                check("stall", out_stall, !hit);
                check("rd", out_mem_rd, !hit && c < 2);
                if (!hit && c == 0) begin
                    check("addr_lo", out_mem_addr, aa);
                    mlast = aa; mlast_known = 1;
                end else if (!hit && c == 1) begin
                    check("addr_hi", out_mem_addr, aa | 12'd1);
                    mlast = aa | 12'd1;
                end else if (mlast_known) begin
                    check("addr_hold", out_mem_addr, mlast);
                end
            end
            if (!hit && c == 2 && fa < 0) begin
                mvalid = 1; maddr = aa; minstr = exp;
            end
            if (c == inval_at) mvalid = 0;
        end
    endtask

    task automatic idle_cycle(input bit inv);
        @(negedge clock);
        in_req   = 0;
        in_flush = 0;
        in_inval = inv;
        #1;
        check("idle_stall", out_stall, 0);
        check("idle_rd", out_mem_rd, 0);
        check("idle_valid", out_instr_valid, 0);
        if (inv) mvalid = 0;
    endtask

    task automatic reset_mid_fetch(input logic [11:0] a);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            in_pmem_addr = a;
            in_req   = 1;
            in_flush = 0;
            in_inval = 0;
        end
        #1;
        check("hi_stall", out_stall, 1);
        reset = 0;
        #1;
        check("rst_instr", out_instr, 0);
        check("rst_valid", out_instr_valid, 0);
        check("rst_stall", out_stall, 0);
        check("rst_rd", out_mem_rd, 0);
        check("rst_addr", out_mem_addr, 0);
        @(negedge clock);
        #1;
        check("rst_valid2", out_instr_valid, 0);
        check("rst_stall2", out_stall, 0);
        reset  = 1;
        in_req = 0;
        mvalid = 0; maddr = '0; minstr = '0; mlast = '0; mlast_known = 1;
    endtask

    initial begin
        logic [11:0] a;
        int          sel;
        int          fa;
        int          ia;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'h34; mem[12'h011] = 8'h12;
        mem[12'hFFE] = 8'hCD; mem[12'hFFF] = 8'hAB;
        reset = 0; in_req = 1; in_pmem_addr = 12'h010; in_flush = 0; in_inval = 0;
        mvalid = 0; maddr = '0; minstr = '0; mlast = '0; mlast_known = 1;
        repeat (3) @(negedge clock);
        #1;
        check("init_instr", out_instr, 0);
        check("init_valid", out_instr_valid, 0);
        check("init_stall", out_stall, 0);
        check("init_rd", out_mem_rd, 0);
        check("init_addr", out_mem_addr, 0);
        reset = 1; in_req = 0;

        fetch(12'h010, -1, -1);
        fetch(12'h010, -1, -1);
        fetch(12'h011, -1, -1);
        fetch(12'hFFE, -1, -1);
        fetch(12'hFFF, -1, -1);
        fetch(12'h020, 1, -1);
        fetch(12'h020, -1, -1);
        fetch(12'h020, 2, -1);
        fetch(12'h010, -1, -1);
        idle_cycle(1);
        fetch(12'h010, -1, -1);
        fetch(12'h020, -1, 2);
        fetch(12'h020, -1, -1);
        fetch(12'h020, 0, -1);
        fetch(12'h020, -1, 0);
        fetch(12'h010, -1, -1);
        reset_mid_fetch(12'h020);
        fetch(12'h010, -1, -1);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: a = 12'h010;
                1: a = 12'h011;
                2: a = 12'h020;
                3: a = 12'hFFE;
                4: a = 12'hFFF;
                default: a = 12'($urandom);
            endcase
            fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            ia = (fa < 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            fetch(a, fa, ia);
            if ($urandom_range(0, 9) == 0) idle_cycle($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) == 0) mem[12'($urandom)] = 8'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pmem_ctrl.md
PMEM_CTRL -- requirements
Module: pmem_ctrl

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 12: fetch address width in bytes.
REQ-002 SHALL have parameter PMEM_WIDTH, default 16: instruction width; fixed at 16, two bytes.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port in_req, input, 1: fetch stage requests the instruction at in_pmem_addr.
REQ-006 SHALL have port in_pmem_addr, input, PC_WIDTH: byte address of the instruction; bit 0 ignored.
REQ-007 SHALL have port in_flush, input, 1: abort any fetch in progress.
REQ-008 SHALL have port in_inval, input, 1: invalidate the one-entry instruction buffer.
REQ-009 SHALL have port out_instr, output, PMEM_WIDTH: returned instruction, registered.
REQ-010 SHALL have port out_instr_valid, output, 1: out_instr valid this cycle, one-cycle pulse.
REQ-011 SHALL have port out_stall, output, 1: fetch stage holds its PC; combinational.
REQ-012 SHALL have port out_mem_rd, output, 1: byte-memory read strobe.
REQ-013 SHALL have port out_mem_addr, output, PC_WIDTH: byte-memory address.
REQ-014 SHALL have port in_mem_data, input, 8: read byte, valid in the cycle after out_mem_rd.

Function
REQ-015 SHALL implement FSM states IDLE, LO, HI.
REQ-016 SHALL form an aligned address Aa = {in_pmem_addr[PC_WIDTH-1:1], 0}.
REQ-017 SHALL hold a one-entry buffer: buf_valid, buf_addr, buf_instr.
REQ-018 SHALL detect a hit in IDLE when in_req=1, buf_valid=1 and buf_addr=Aa.
REQ-019 On a hit, SHALL load out_instr <= buf_instr, set out_instr_valid=1 next cycle, keep out_stall=0, stay in IDLE, and issue no memory read.
REQ-020 On a miss in IDLE, SHALL drive out_mem_rd=1 with out_mem_addr=Aa combinationally, capture Aa into addr_reg, and go to LO.
REQ-021 In LO, SHALL load lo_reg <= in_mem_data, drive out_mem_rd=1 with out_mem_addr=addr_reg+1, and go to HI.
REQ-022 In HI, SHALL load out_instr <= {in_mem_data, lo_reg} (little-endian), pulse out_instr_valid next cycle, write buf <= {1, addr_reg, instr}, and go to IDLE.
REQ-023 Miss latency SHALL be 3 cycles: request in cycle 0, valid in cycle 3.
REQ-024 out_stall SHALL be 1 when state is LO or HI, or when state is IDLE with in_req=1 and no hit; otherwise 0.
REQ-025 addr_reg+1 SHALL NOT wrap, because addr_reg is even; the top address pair (2^PC_WIDTH-2, 2^PC_WIDTH-1) SHALL be fetched normally.
REQ-026 out_mem_rd SHALL be 0 and out_mem_addr SHALL hold its last value whenever no read is issued.
REQ-027 in_flush=1 in any state SHALL force next state IDLE, suppress out_instr_valid, leave buf unchanged, and override in_req in that cycle.
REQ-028 out_stall SHALL be 0 during a flush cycle.
REQ-029 in_inval=1 SHALL clear buf_valid next cycle.
REQ-030 in_inval SHALL override a simultaneous buf write from HI; that fetch still returns out_instr_valid.
REQ-031 in_inval SHALL NOT alter a hit decision made in the same cycle.
REQ-032 in_req is only sampled in IDLE; while stalled, the fetch stage holds in_pmem_addr stable and the block ignores changes to it.

Reset
REQ-033 While reset=0: state=IDLE, out_instr=0, out_instr_valid=0, buf_valid=0, buf_addr=0, buf_instr=0, lo_reg=0, addr_reg=0, out_mem_addr=0, out_mem_rd=0; out_stall=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch immediately with no valid pulse; on release, operation resumes from IDLE on the next rising edge.

Verification
REQ-035 Miss: mem[0x010]=0x34, mem[0x011]=0x12, req addr 0x010 -> out_mem_rd at 0x010 then 0x011, out_stall=1 for 3 cycles, cycle 3 out_instr=0x1234, out_instr_valid=1.
REQ-036 Hit: repeat req 0x010 -> no out_mem_rd, out_stall=0, next cycle out_instr=0x1234, out_instr_valid=1.
REQ-037 Odd address and top of memory: req 0x011 -> returns 0x1234; req 0xFFE with mem[0xFFE]=0xCD, mem[0xFFF]=0xAB -> 0xABCD, with out_mem_addr sequence 0xFFE, 0xFFF.
REQ-038 Flush: req 0x020 miss, in_flush=1 in the LO cycle -> IDLE next cycle, no valid pulse; a later req 0x020 is a miss with a full 3-cycle fetch.
REQ-039 Invalidate: after buffering 0x010, pulse in_inval, then req 0x010 -> miss with a 3-cycle fetch; in_inval coincident with HI -> valid pulse still occurs, next req is a miss.
REQ-040 Reset: assert reset=0 during HI -> all outputs zero immediately, no valid pulse; after release, req 0x010 is a miss.
